// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and constants for the main-memory fill arbiter: state
// encoding, block geometry and a helper for word-to-byte offsets.
package mem_fill_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWRITE = 2'd1,
        ST_DFILL  = 2'd2,
        ST_IFILL  = 2'd3
    } arb_state_t;

    localparam int BLK_OFF_BITS = 4;
    localparam int IDX_W        = 3;

    // Byte offset of a 16-bit word inside a block.
    function automatic logic [IDX_W:0] word_offset(input logic [IDX_W-1:0] idx);
        return {idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_block_word_counter.sv
// Word counter for one block transfer: synchronous clear, count enable and
// a terminal-count flag on the last word of the block.
module block_word_counter
    import mem_fill_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [IDX_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = &count;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Shares the single multi-cycle main memory between I-cache and D-cache
// miss paths: 8-word block fills and single-word write-through stores.
module mem_fill_arbiter
    import mem_fill_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8,
    parameter int MEM_LAT   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imiss_req,
    input  logic [ADDR_W-1:0] imiss_addr,
    input  logic              dmiss_req,
    input  logic [ADDR_W-1:0] dmiss_addr,
    input  logic              dwr_req,
    input  logic [ADDR_W-1:0] dwr_addr,
    input  logic [DATA_W-1:0] dwr_data,
    output logic              ifill_valid,
    output logic              dfill_valid,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [DATA_W-1:0] fill_data,
    output logic              ifill_done,
    output logic              dfill_done,
    output logic              dwr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid
);

    if (BLK_WORDS != (1 << IDX_W) || MEM_LAT < 1) begin : g_param_check
        $error("mem_fill_arbiter: unsupported BLK_WORDS/MEM_LAT combination");
    end

    arb_state_t        state;
    logic [ADDR_W-1:0] base;
    logic              iss_all;
    logic              in_fill;
    logic              cnt_clear;
    logic              iss_en;
    logic              rcv_en;
    logic              iss_tc;
    logic              rcv_tc;
    logic              last_word;
    logic [IDX_W-1:0]  iss_cnt;
    logic [IDX_W-1:0]  rcv_cnt;
    logic              unused_low_bits;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:BLK_OFF_BITS], {BLK_OFF_BITS{1'b0}}};
    endfunction

    assign in_fill   = (state == ST_DFILL) || (state == ST_IFILL);
    assign cnt_clear = (state == ST_IDLE);
    assign iss_en    = in_fill && !iss_all;
    // Returning words are only accepted while a fill owns the memory.
    assign rcv_en    = in_fill && mem_data_valid;
    assign last_word = rcv_en && rcv_tc;

    // Miss addresses are block-aligned on grant, so their low bits never matter.
    assign unused_low_bits = ^{imiss_addr[BLK_OFF_BITS-1:0], dmiss_addr[BLK_OFF_BITS-1:0]};

    block_word_counter u_iss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .en    (iss_en),
        .count (iss_cnt),
        .tc    (iss_tc)
    );

    block_word_counter u_rcv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .en    (rcv_en),
        .count (rcv_cnt),
        .tc    (rcv_tc)
    );

    // Requests are only looked at in IDLE; D side wins as the older instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            base    <= '0;
            iss_all <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    iss_all <= 1'b0;
                    if (dwr_req) begin
                        state <= ST_DWRITE;
                        base  <= block_base(dwr_addr);
                    end else if (dmiss_req) begin
                        state <= ST_DFILL;
                        base  <= block_base(dmiss_addr);
                    end else if (imiss_req) begin
                        state <= ST_IFILL;
                        base  <= block_base(imiss_addr);
                    end
                end
                ST_DWRITE: begin
                    state <= ST_IDLE;
                end
                ST_DFILL, ST_IFILL: begin
                    if (iss_en && iss_tc) begin
                        iss_all <= 1'b1;
                    end
                    if (last_word) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ifill_valid = 1'b0;
        dfill_valid = 1'b0;
        fill_idx    = '0;
        ifill_done  = 1'b0;
        dfill_done  = 1'b0;
        dwr_ack     = 1'b0;
        mem_addr    = '0;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_data_in = '0;
        case (state)
            ST_DWRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = dwr_addr;
                mem_data_in = dwr_data;
                dwr_ack     = 1'b1;
            end
            ST_DFILL, ST_IFILL: begin
                if (iss_en) begin
                    mem_enable = 1'b1;
                    // Base is block-aligned, so OR-ing the offset cannot carry out of the block.
                    mem_addr   = base | ADDR_W'(word_offset(iss_cnt));
                end
                if (rcv_en) begin
                    fill_idx = rcv_cnt;
                    if (state == ST_DFILL) begin
                        dfill_valid = 1'b1;
                        dfill_done  = rcv_tc;
                    end else begin
                        ifill_valid = 1'b1;
                        ifill_done  = rcv_tc;
                    end
                end
            end
            default: ;
        endcase
    end

    assign fill_data = mem_data_out;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: a latency-4 memory model, a
// transaction-level reference of grant order and block contents, and a word scoreboard.
module tb_mem_fill_arbiter;

  localparam int K_WR = 0;
  localparam int K_D  = 1;
  localparam int K_I  = 2;

  logic        clk;
  logic        rst_n;
  logic        imiss_req;
  logic [15:0] imiss_addr;
  logic        dmiss_req;
  logic [15:0] dmiss_addr;
  logic        dwr_req;
  logic [15:0] dwr_addr;
  logic [15:0] dwr_data;
  logic        ifill_valid;
  logic        dfill_valid;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic        ifill_done;
  logic        dfill_done;
  logic        dwr_ack;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_fill_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imiss_req      (imiss_req),
    .imiss_addr     (imiss_addr),
    .dmiss_req      (dmiss_req),
    .dmiss_addr     (dmiss_addr),
    .dwr_req        (dwr_req),
    .dwr_addr       (dwr_addr),
    .dwr_data       (dwr_data),
    .ifill_valid    (ifill_valid),
    .dfill_valid    (dfill_valid),
    .fill_idx       (fill_idx),
    .fill_data      (fill_data),
    .ifill_done     (ifill_done),
    .dfill_done     (dfill_done),
    .dwr_ack        (dwr_ack),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid)
  );

  // ---------------- main memory model ----------------
  logic [15:0] seed;
  logic [15:0] wr_mem [0:32767];
  bit          wr_flag [0:32767];
  bit   [3:0]  pv;
  logic [15:0] pd [4];
  logic        stray_valid;
  logic [15:0] stray_data;

  function automatic logic [15:0] init_word(input logic [14:0] wa);
    return 16'({wa, 1'b1} * 16'h9E37) ^ seed;
  endfunction

  always @(posedge clk) begin
    if (mem_enable && mem_wr) begin
      wr_mem[mem_addr[15:1]]  <= mem_data_in;
      wr_flag[mem_addr[15:1]] <= 1'b1;
    end
    pv    <= {pv[2:0], mem_enable && !mem_wr};
    pd[0] <= wr_flag[mem_addr[15:1]] ? wr_mem[mem_addr[15:1]] : init_word(mem_addr[15:1]);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end

  assign mem_data_valid = pv[3] | stray_valid;
  assign mem_data_out   = stray_valid ? stray_data : pd[3];

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] exp_mem [int];
  logic [18:0] exp_q [$];

  function automatic logic [15:0] model_word(input logic [14:0] wa);
    if (exp_mem.exists(int'(wa))) return exp_mem[int'(wa)];
    return init_word(wa);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_en"}, 32'(mem_enable), 0);
    check_eq({tag, "_wr"}, 32'(mem_wr), 0);
    check_eq({tag, "_valid"}, 32'({ifill_valid, dfill_valid}), 0);
    check_eq({tag, "_done"}, 32'({ifill_done, dfill_done, dwr_ack}), 0);
  endtask

  task automatic drop_req(input int kind);
    if (kind == K_I) imiss_req = 1'b0;
    else if (kind == K_D) dmiss_req = 1'b0;
    else dwr_req = 1'b0;
  endtask

  // One granted transaction, starting at the negedge just before its grant edge.
  task automatic run_txn(input int kind, input logic [15:0] addr, input logic [15:0] data, input bit drop);
    logic [15:0] base;
    logic [18:0] e;
    base = {addr[15:4], 4'h0};
    if (kind == K_WR) begin
      exp_mem[int'(addr[15:1])] = data;
      @(negedge clk);
      check_eq("wr_en", 32'(mem_enable), 1);
      check_eq("wr_wr", 32'(mem_wr), 1);
      check_eq("wr_addr", 32'(mem_addr), 32'(addr));
      check_eq("wr_data", 32'(mem_data_in), 32'(data));
      check_eq("dwr_ack", 32'(dwr_ack), 1);
      check_eq("wr_no_fill", 32'({ifill_valid, dfill_valid, ifill_done, dfill_done}), 0);
      drop_req(K_WR);
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back({3'(i), model_word(base[15:1] + 15'(i))});
      end
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        check_eq("fill_en", 32'(mem_enable), 32'(k < 8));
        if (k < 8) begin
          check_eq("fill_rd", 32'(mem_wr), 0);
          check_eq("fill_addr", 32'(mem_addr), 32'(base + 16'(2 * k)));
        end
        check_eq("ifill_valid", 32'(ifill_valid), 32'(kind == K_I && k >= 4));
        check_eq("dfill_valid", 32'(dfill_valid), 32'(kind == K_D && k >= 4));
        check_eq("ifill_done", 32'(ifill_done), 32'(kind == K_I && k == 11));
        check_eq("dfill_done", 32'(dfill_done), 32'(kind == K_D && k == 11));
        check_eq("fill_no_ack", 32'(dwr_ack), 0);
        if (ifill_valid || dfill_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_word", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("fill_idx", 32'(fill_idx), 32'(e[18:16]));
            check_eq("fill_data", 32'(fill_data), 32'(e[15:0]));
          end
        end
        if ((k == 0 && drop) || k == 11) drop_req(kind);
      end
      check_eq("words_left", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge clk);
    check_idle("post_idle");
  endtask

  // Requests raised together are served strictly in priority order.
  task automatic run_trial(input bit wr, input bit d, input bit i,
                           input logic [15:0] wa, input logic [15:0] wd,
                           input logic [15:0] da, input logic [15:0] ia,
                           input bit drop_d, input bit drop_i);
    dwr_req = wr;  dwr_addr = wa;  dwr_data = wd;
    dmiss_req = d; dmiss_addr = da;
    imiss_req = i; imiss_addr = ia;
    if (wr) run_txn(K_WR, wa, wd, 1'b0);
    if (d)  run_txn(K_D, da, 16'h0, drop_d);
    if (i)  run_txn(K_I, ia, 16'h0, drop_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    seed = 16'($urandom);
    stray_valid = 1'b0;
    stray_data = 16'h0;
    rst_n = 1'b0;
    imiss_req = 1'b1;  imiss_addr = 16'h1236;
    dmiss_req = 1'b1;  dmiss_addr = 16'h2000;
    dwr_req = 1'b1;    dwr_addr = 16'h3000; dwr_data = 16'h5555;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_addr", 32'(mem_addr), 0);
    check_eq("reset_idx", 32'(fill_idx), 0);
    imiss_req = 1'b0; dmiss_req = 1'b0; dwr_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    // I fill at 0x1236
    run_trial(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h1236, 0, 0);
    // store and I miss together: store first
    run_trial(1, 0, 1, 16'h1234, 16'hA5A5, 16'h0, 16'h1236, 0, 0);
    // D miss at top of memory and I miss together
    run_trial(0, 1, 1, 16'h0, 16'h0, 16'hFFF2, 16'h0104, 0, 0);
    // same block on both sides, plus a store into it
    run_trial(1, 1, 1, 16'h7788, 16'h1357, 16'h778A, 16'h778E, 0, 0);
    // requester drops right after grant
    run_trial(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h4442, 0, 1);

    // stray memory valid while idle
    stray_valid = 1'b1;
    stray_data = 16'hBEEF;
    #1;
    check_idle("stray");
    @(negedge clk);
    stray_valid = 1'b0;
    check_idle("stray_after");
    run_trial(0, 1, 0, 16'h0, 16'h0, 16'h2468, 16'h0, 0, 0);

    // reset in fill cycle 5 with reads still in flight
    imiss_req = 1'b1;
    imiss_addr = 16'h4A5C;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("pre_rst_en", 32'(mem_enable), 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    imiss_req = 1'b0;
    #1;
    check_idle("mid_rst");
    check_eq("mid_rst_addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_idle("post_rst");
    end
    run_trial(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h4A5C, 0, 0);

    // randomized mixes
    for (int t = 0; t < 40; t++) begin
      bit wr, d, i;
      logic [15:0] wa, da, ia;
      wr = 1'($urandom_range(0, 1));
      d  = 1'($urandom_range(0, 1));
      i  = 1'($urandom_range(0, 1));
      if (!wr && !d && !i) i = 1'b1;
      wa = 16'($urandom_range(0, 65535));
      da = 16'($urandom_range(0, 65535));
      ia = ($urandom_range(0, 2) == 0) ? da : 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) wa = {da[15:4], wa[3:0]};
      run_trial(wr, d, i, wa, 16'($urandom), da, ia,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
